ps2_frame_rx: RTL and testbench

//  Receives PS/2 device-to-host frames on ps2_clk/ps2_dat and delivers checked scan-code bytes.

---
 rtl/ps2_frame_rx.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises and glitch-filters ps2_clk/ps2_dat,
// deserialises start/8 data/odd parity/stop frames and emits checked scan-code bytes.
// Optional feature: define PS2_RX_MAKEBREAK_EN to fold F0/E0 prefixes into key_break/key_ext.
// Ports: CLOCK_50, Resetn (async, active low), ps2_clk, ps2_dat in;
//        scan_code[7:0], code_valid, parity_err, frame_err, busy, key_break, key_ext out.
module ps2_frame_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy,
    output logic       key_break,
    output logic       key_ext
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_s, dat_s;
    logic                   filt, filt_d;
    logic [FW-1:0]          fcnt;
    logic                   fall;

    state_t        state, state_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [8:0]    shreg, shreg_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          timeout;
    logic          good, perr_c, ferr_c;

    // Both lines idle high, so the chains come out of reset at 1.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];

    // filt follows clk_s only after FILTER_LEN consecutive differing cycles.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
        end else begin
            filt_d <= filt;
            if (clk_s != filt) begin
                if (fcnt == FW'(FILTER_LEN - 1)) begin
                    filt <= clk_s;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign fall    = filt_d & ~filt;
    assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign busy    = (state != IDLE);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            tcnt   <= tcnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        tcnt_n   = tcnt;
        good     = 1'b0;
        perr_c   = 1'b0;
        ferr_c   = 1'b0;
        if (state != IDLE)
            tcnt_n = tcnt + TW'(1);
        // Timeout wins over a coincident fall.
        if (timeout) begin
            state_n = IDLE;
            tcnt_n  = '0;
            ferr_c  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fall && !dat_s) begin
                        state_n  = RECV;
                        bitcnt_n = '0;
                        tcnt_n   = '0;
                    end
                end
                RECV: begin
                    if (fall) begin
                        shreg_n  = {dat_s, shreg[8:1]};
                        bitcnt_n = bitcnt + 4'd1;
                        tcnt_n   = '0;
                        if (bitcnt == 4'd8)
                            state_n = STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        state_n = IDLE;
                        tcnt_n  = '0;
                        if (!dat_s)
                            ferr_c = 1'b1;
                        else if (^shreg)
                            good = 1'b1;
                        else
                            perr_c = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef PS2_RX_MAKEBREAK_EN
    logic break_pend, ext_pend;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            scan_code  <= '0;
            code_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            key_break  <= 1'b0;
            key_ext    <= 1'b0;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            parity_err <= perr_c;
            frame_err  <= ferr_c;
            if (perr_c || ferr_c) begin
                break_pend <= 1'b0;
                ext_pend   <= 1'b0;
            end
            if (good) begin
                if (shreg[7:0] == 8'hF0) begin
                    break_pend <= 1'b1;
                end else if (shreg[7:0] == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else begin
                    scan_code  <= shreg[7:0];
                    code_valid <= 1'b1;
                    key_break  <= break_pend;
                    key_ext    <= ext_pend;
                    break_pend <= 1'b0;
                    ext_pend   <= 1'b0;
                end
            end
        end
    end
`else
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            scan_code  <= '0;
            code_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= good;
            parity_err <= perr_c;
            frame_err  <= ferr_c;
            if (good)
                scan_code <= shreg[7:0];
        end
    end

    assign key_break = 1'b0;
    assign key_ext   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Testbench for ps2_frame_rx: table of frames driven on the PS/2 lines,
// expected strobes queued and checked by a monitor, plus corner-case sequences.
module tb_ps2_frame_rx;

    localparam int H   = 20;
    localparam int TMO = 50000;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_dat  = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid, parity_err, frame_err, busy, key_break, key_ext;

    ps2_frame_rx dut (
        .CLOCK_50  (CLOCK_50),
        .Resetn    (Resetn),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .scan_code (scan_code),
        .code_valid(code_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy),
        .key_break (key_break),
        .key_ext   (key_ext)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        logic       badp;
        logic       stop;
    } vec_t;

    ev_t        q[$];
    vec_t       tab[13];
    int         ncmp = 0;
    int         nerr = 0;
    logic [7:0] last_good = 8'h00;
    logic       bp = 1'b0;
    logic       ep = 1'b0;
    ev_t        mon_e;
    int         mon_k;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Strobe monitor: every strobe must match the head of the queue.
    always @(negedge CLOCK_50) begin
        if (Resetn && (code_valid || parity_err || frame_err)) begin
            mon_k = code_valid ? 0 : (parity_err ? 1 : 2);
            ncmp++;
            if (int'(code_valid) + int'(parity_err) + int'(frame_err) > 1) begin
                nerr++;
                $display("FAIL multi_strobe: got v%0d p%0d f%0d expected one",
                         code_valid, parity_err, frame_err);
            end else if (q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_strobe: got kind %0d expected none", mon_k);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.kind != mon_k ||
                    (mon_k == 0 && (scan_code !== mon_e.code ||
                     key_break !== mon_e.brk || key_ext !== mon_e.ext))) begin
                    nerr++;
                    $display("FAIL strobe: got kind %0d code %0h b%0d e%0d expected kind %0d code %0h b%0d e%0d",
                             mon_k, scan_code, key_break, key_ext,
                             mon_e.kind, mon_e.code, mon_e.brk, mon_e.ext);
                end
            end
        end
    end

    // Reference model of what a frame should produce.
    task automatic expect_frame(input logic [7:0] d, input logic badp, input logic stop,
                                output bit strobe);
        strobe = 1'b1;
        if (!stop) begin
            q.push_back('{2, 8'h00, 1'b0, 1'b0});
            bp = 1'b0;
            ep = 1'b0;
        end else if (badp) begin
            q.push_back('{1, 8'h00, 1'b0, 1'b0});
            bp = 1'b0;
            ep = 1'b0;
        end else begin
`ifdef PS2_RX_MAKEBREAK_EN
            if (d == 8'hF0) begin
                bp = 1'b1;
                strobe = 1'b0;
            end else if (d == 8'hE0) begin
                ep = 1'b1;
                strobe = 1'b0;
            end else begin
                q.push_back('{0, d, bp, ep});
                last_good = d;
                bp = 1'b0;
                ep = 1'b0;
            end
`else
            q.push_back('{0, d, 1'b0, 1'b0});
            last_good = d;
`endif
        end
    endtask

    // Drives the first nbits bits of a frame; optionally measures strobe latency
    // from the stop-bit fall.
    task automatic send_frame(input logic [7:0] d, input logic badp, input logic stop,
                              input int nbits, input bit chk_lat);
        logic [10:0] bits;
        int          n;
        bits = {stop, (~^d) ^ badp, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLOCK_50);
            ps2_dat = bits[i];
            wait_cyc(H);
            ps2_clk = 1'b0;
            if (i == 10 && chk_lat) begin
                n = 0;
                while (n < 30) begin
                    @(posedge CLOCK_50);
                    n++;
                    #1;
                    if (code_valid || parity_err || frame_err)
                        break;
                end
                check("strobe_latency", n, 7);
            end
            wait_cyc(H);
            if (i == 0)
                check("busy_in_frame", busy, 1);
            ps2_clk = 1'b1;
        end
        if (nbits == 11) begin
            @(negedge CLOCK_50);
            ps2_dat = 1'b1;
            wait_cyc(H);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit s;
        expect_frame(v.data, v.badp, v.stop, s);
        send_frame(v.data, v.badp, v.stop, 11, s);
        wait_cyc(4);
        check("busy_after", busy, 0);
        check("scan_code_held", scan_code, last_good);
    endtask

    initial begin
        int  n;
        bit  gl_busy;
        bit  s;

        tab[0]  = '{8'h1C, 1'b0, 1'b1};
        tab[1]  = '{8'h1C, 1'b1, 1'b1};
        tab[2]  = '{8'h1C, 1'b0, 1'b0};
        tab[3]  = '{8'h32, 1'b0, 1'b1};
        tab[4]  = '{8'h00, 1'b0, 1'b1};
        tab[5]  = '{8'hFF, 1'b0, 1'b1};
        tab[6]  = '{8'hA5, 1'b1, 1'b1};
        tab[7]  = '{8'h5A, 1'b0, 1'b0};
        tab[8]  = '{8'hF0, 1'b0, 1'b1};
        tab[9]  = '{8'h1C, 1'b0, 1'b1};
        tab[10] = '{8'hE0, 1'b0, 1'b1};
        tab[11] = '{8'hF0, 1'b0, 1'b1};
        tab[12] = '{8'h75, 1'b0, 1'b1};

        wait_cyc(5);
        check("rst_scan_code", scan_code, 0);
        check("rst_strobes", {code_valid, parity_err, frame_err}, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {key_break, key_ext}, 0);
        Resetn = 1'b1;
        wait_cyc(10);

        for (int i = 0; i < 13; i++)
            run_vec(tab[i]);

        // Short low glitch on ps2_clk while idle with data low.
        @(negedge CLOCK_50);
        ps2_dat = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
        gl_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_cyc(1);
            gl_busy |= busy;
        end
        check("glitch_busy", gl_busy, 0);
        ps2_dat = 1'b1;
        wait_cyc(H);

        // Abandoned frame: start + 3 data bits then clock held high.
        expect_frame(8'h00, 1'b0, 1'b0, s);
        send_frame(8'h1C, 1'b0, 1'b1, 4, 1'b0);
        check("busy_before_timeout", busy, 1);
        n = 0;
        while (!frame_err && n < 60000) begin
            @(posedge CLOCK_50);
            n++;
            #1;
        end
        check("timeout_fired", frame_err, 1);
        check("timeout_window", (n >= TMO - H - 30 && n <= TMO - H + 10), 1);
        wait_cyc(2);
        check("busy_after_timeout", busy, 0);
        wait_cyc(H);
        run_vec('{8'h1C, 1'b0, 1'b1});

        // Reset in the middle of a frame.
        send_frame(8'h4B, 1'b0, 1'b1, 5, 1'b0);
        @(negedge CLOCK_50);
        Resetn = 1'b0;
        wait_cyc(3);
        check("midrst_busy", busy, 0);
        check("midrst_scan_code", scan_code, 0);
        last_good = 8'h00;
        bp = 1'b0;
        ep = 1'b0;
        Resetn = 1'b1;
        wait_cyc(H);
        run_vec('{8'h29, 1'b0, 1'b1});

        wait_cyc(H);
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
